// File: rtl/d_flip_flop_pkg.sv
// Shared limits and helpers for the d_flip_flop retiming primitive.
// Legal pipeline depth is bounded so that the chain stays a short retiming element.
package d_flip_flop_pkg;

    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 16;

    function automatic bit stages_legal(input int stages);
        return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/d_flip_flop_stage.sv
// One WIDTH-bit register stage with asynchronous active-low reset to RST_VAL.
module d_flip_flop_stage #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Reset is in the sensitivity list so assertion wins even on a coincident clk edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/d_flip_flop.sv
// Parameterised D flip-flop: STAGES series registers of WIDTH bits, async active-low reset.
// Q is driven straight from the last stage; there is no combinational path from D.
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               STAGES  = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("d_flip_flop: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
    end

    // w_chain[0] is the input tap; w_chain[gi+1] is the output of stage gi.
    logic [STAGES:0][WIDTH-1:0] w_chain;

    assign w_chain[0] = D;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        d_flip_flop_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .n_rst (n_rst),
            .i_d   (w_chain[gi]),
            .o_q   (w_chain[gi+1])
        );
    end

    assign Q = w_chain[STAGES];

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: default 1-bit/1-stage instance plus an 8-bit/3-stage instance.
module tb_d_flip_flop;

    logic       clk;
    logic       n_rst;
    logic [0:0] d;
    logic [0:0] q;
    logic       p_n_rst;
    logic [7:0] p_d;
    logic [7:0] p_q;

    int n_cmp;
    int n_bad;

    d_flip_flop u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .D     (d),
        .Q     (q)
    );

    d_flip_flop #(
        .WIDTH   (8),
        .RST_VAL (8'hA5),
        .STAGES  (3)
    ) u_dut_p (
        .clk   (clk),
        .n_rst (p_n_rst),
        .D     (p_d),
        .Q     (p_q)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       din;
        logic       exp_q;
    } vec1_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_q;
    } vec8_t;

    vec1_t v1 [10];
    vec8_t v8 [10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        v1[0] = '{1'b1, 1'b0, 1'b0};
        v1[1] = '{1'b1, 1'b1, 1'b1};
        v1[2] = '{1'b1, 1'b0, 1'b0};
        v1[3] = '{1'b1, 1'b1, 1'b1};
        v1[4] = '{1'b0, 1'b1, 1'b0};
        v1[5] = '{1'b0, 1'b1, 1'b0};
        v1[6] = '{1'b1, 1'b1, 1'b1};
        v1[7] = '{1'b1, 1'b0, 1'b0};
        v1[8] = '{1'b1, 1'b1, 1'b1};
        v1[9] = '{1'b1, 1'b1, 1'b1};

        v8[0] = '{8'h3C, 8'h00};
        v8[1] = '{8'h00, 8'h00};
        v8[2] = '{8'h00, 8'h3C};
        v8[3] = '{8'h00, 8'h00};
        v8[4] = '{8'h11, 8'h00};
        v8[5] = '{8'h22, 8'h00};
        v8[6] = '{8'h33, 8'h11};
        v8[7] = '{8'h00, 8'h22};
        v8[8] = '{8'h00, 8'h33};
        v8[9] = '{8'h00, 8'h00};

        // Reset hold from time 0 (clk starts high, first rising edge at 10 ns).
        n_rst   = 1'b0;
        d       = 1'b0;
        p_n_rst = 1'b0;
        p_d     = 8'h00;
        #1;
        check("reset_q", {7'b0, q}, 8'h00);
        check("reset_pq", p_q, 8'hA5);
        #3;
        check("reset_hold_q", {7'b0, q}, 8'h00);

        #1;  // t=5
        n_rst   = 1'b1;
        p_n_rst = 1'b1;
        #10; // t=15
        d = 1'b1;
        #4;  // t=19
        check("before_edge20", {7'b0, q}, 8'h00);
        #2;  // t=21
        check("after_edge20", {7'b0, q}, 8'h01);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_rst = v1[i].rst_n;
            d     = v1[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec1[%0d]", i), {7'b0, q}, {7'b0, v1[i].exp_q});
        end

        // Async reset mid-cycle with Q=1: must clear without a clk edge.
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_clr", {7'b0, q}, 8'h00);
        @(posedge clk);
        #1;
        check("async_hold", {7'b0, q}, 8'h00);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("release_no_edge", {7'b0, q}, 8'h00);
        @(posedge clk);
        #1;
        check("first_after_release", {7'b0, q}, 8'h01);

        // D changes between edges do not disturb Q.
        #2 d = 1'b0;
        #1 d = 1'b1;
        #1;
        check("hold_between_edges", {7'b0, q}, 8'h01);

        // Mid-cycle glitch on D while Q=0.
        @(negedge clk);
        d = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_pre", {7'b0, q}, 8'h00);
        #2 d = 1'b1;
        #2 d = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_post", {7'b0, q}, 8'h00);

        // Reset asserted coincident with a rising edge while D=1.
        @(negedge clk);
        d = 1'b1;
        @(posedge clk);
        n_rst = 1'b0;
        #1;
        check("coincident_rst", {7'b0, q}, 8'h00);
        @(negedge clk);
        n_rst = 1'b1;
        d     = 1'b0;

        // Pipelined instance: all stages hold 0 by now.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            p_d = v8[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec8[%0d]", i), p_q, v8[i].exp_q);
        end

        // Flush in-flight 5A with a mid-cycle reset; it must never reach Q.
        @(negedge clk);
        p_d = 8'h5A;
        @(negedge clk);
        p_d = 8'h00;
        @(posedge clk);
        #2;
        p_n_rst = 1'b0;
        #1;
        check("p_async_clr", p_q, 8'hA5);
        @(posedge clk);
        #1;
        check("p_rst_hold", p_q, 8'hA5);
        @(negedge clk);
        p_n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("p_flush[%0d]", i), p_q, (i < 2) ? 8'hA5 : 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: got running expected done at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
